// File: rtl/if_id_stage.sv
// if_id_stage
//   Instruction fetch and IF/ID pipeline register for the 16-bit RISC core.
//   Owns the PC, reads instruction memory combinationally, and holds the
//   fetched word with a valid bit. Register/immediate fields are sliced
//   combinationally from the held word. A two-state RUN/HALT FSM stops
//   fetch when a HALT instruction reaches IF/ID; only rst_n leaves HALT.
//
// Handshake: there is no valid/ready pair here. stall, flush and redirect
//   are level-sensitive controls sampled on each rising edge in RUN.
//   id_valid qualifies id_instr; it is not back-pressured by a ready.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   imem_addr/imem_data instruction memory address (= pc) and word
//   stall/flush         hold pipeline / squash IF/ID
//   redirect/redirect_pc taken branch and its target
//   id_valid/id_instr/id_pc_next  IF/ID register contents
//   opcode/rd/rs/rt/const_in/SEOp decoded fields for ID
//   halted              FSM state (1 = HALT); doubles as FSM debug view
//   stall_cnt           saturating stall counter (IF_ID_STALL_CNT_EN only)
//
// Configuration: define IF_ID_STALL_CNT_EN to add the stall_cnt output.
module if_id_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_WORD = 16'h0000,
  parameter logic [3:0]  HALT_OPC = 4'hF,
  parameter logic [3:0]  SHL_OPC  = 4'hA,
  parameter logic [3:0]  SHR_OPC  = 4'hB
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        id_valid,
  output logic [15:0] id_instr,
  output logic [15:0] id_pc_next,
  output logic [3:0]  opcode,
  output logic [2:0]  rd,
  output logic [2:0]  rs,
  output logic [2:0]  rt,
  output logic [5:0]  const_in,
  output logic        SEOp,
  output logic        halted
`ifdef IF_ID_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q;
  logic        run_en;   // RUN and not on the edge that enters HALT

  // Decode is pure slicing of the held word; no added latency.
  assign opcode    = id_instr[15:12];
  assign rd        = id_instr[11:9];
  assign rs        = id_instr[8:6];
  assign rt        = id_instr[5:3];
  assign const_in  = id_instr[5:0];
  assign SEOp      = id_valid && ((opcode == SHL_OPC) || (opcode == SHR_OPC));
  assign halted    = (state_q == HALT);
  assign imem_addr = pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  // The edge that enters HALT also freezes pc and IF/ID so the HALT word
  // stays visible in IF/ID rather than being overwritten by the next fetch.
  always_comb begin
    state_d = state_q;
    run_en  = 1'b0;
    if (state_q == RUN) begin
      if (id_valid && (opcode == HALT_OPC) && !flush && !redirect)
        state_d = HALT;
      else
        run_en = 1'b1;
    end
  end

  // PC: redirect > stall > increment (wraps naturally mod 2^16).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (run_en) begin
      if (redirect)    pc_q <= redirect_pc;
      else if (!stall) pc_q <= pc_q + 16'd1;
    end
  end

  // IF/ID: redirect = flush > stall > load. Squash keeps id_pc_next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_instr   <= NOP_WORD;
      id_pc_next <= 16'h0000;
      id_valid   <= 1'b0;
    end else if (run_en) begin
      if (redirect || flush) begin
        id_instr <= NOP_WORD;
        id_valid <= 1'b0;
      end else if (!stall) begin
        id_instr   <= imem_data;
        id_pc_next <= pc_q + 16'd1;
        id_valid   <= 1'b1;
      end
    end
  end

`ifdef IF_ID_STALL_CNT_EN
  // Counts every RUN edge with a non-redirected stall, including the edge
  // that enters HALT; frozen once in HALT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 16'h0000;
    end else if ((state_q == RUN) && stall && !redirect &&
                 (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage
//   Directed scenarios plus randomized control traffic for if_id_stage,
//   checked against a cycle-level behavioural model of fetch/IF-ID/HALT.
module tb_if_id_stage;

  localparam int EW = 70;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        id_valid;
  logic [15:0] id_instr;
  logic [15:0] id_pc_next;
  logic [3:0]  opcode;
  logic [2:0]  rd;
  logic [2:0]  rs;
  logic [2:0]  rt;
  logic [5:0]  const_in;
  logic        SEOp;
  logic        halted;
`ifdef IF_ID_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  logic [15:0] mem [0:65535];
  assign imem_data = mem[imem_addr];

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [15:0] m_pc, m_instr, m_pcn, m_scnt;
  logic        m_valid, m_halted;
  logic [EW-1:0] exp_q[$];

  if_id_stage dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .flush(flush), .redirect(redirect),
    .redirect_pc(redirect_pc), .id_valid(id_valid), .id_instr(id_instr),
    .id_pc_next(id_pc_next), .opcode(opcode), .rd(rd), .rs(rs), .rt(rt),
    .const_in(const_in), .SEOp(SEOp), .halted(halted)
`ifdef IF_ID_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic model_reset;
    m_pc = 16'h0000; m_instr = 16'h0000; m_pcn = 16'h0000;
    m_valid = 1'b0; m_halted = 1'b0; m_scnt = 16'h0000;
  endtask

  // Called at a negedge; leaves the bench at the next negedge with reset
  // released so the first posedge after release performs the first fetch.
  task automatic apply_reset;
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0;
    redirect_pc = 16'h0000;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- reference model ----------------
  task automatic model_step(input logic s, input logic f, input logic r,
                            input logic [15:0] rp);
    logic [15:0] nxt;
    if (!m_halted) begin
      if (s && !r && m_scnt != 16'hFFFF) m_scnt = m_scnt + 16'd1;
      if (m_valid && m_instr[15:12] == 4'hF && !f && !r) begin
        m_halted = 1'b1;
      end else begin
        nxt = r ? rp : (s ? m_pc : m_pc + 16'd1);
        if (r || f) begin
          m_instr = 16'h0000; m_valid = 1'b0;
        end else if (!s) begin
          m_instr = mem[m_pc]; m_pcn = m_pc + 16'd1; m_valid = 1'b1;
        end
        m_pc = nxt;
      end
    end
  endtask

  function automatic logic [EW-1:0] model_view();
    logic [3:0] op;
    op = m_instr[15:12];
    return {m_pc, m_valid, m_instr, m_pcn, op, m_instr[11:9], m_instr[8:6],
            m_instr[5:3], m_instr[5:0],
            m_valid && (op == 4'hA || op == 4'hB), m_halted};
  endfunction

  // ---------------- driver ----------------
  task automatic cycle(input logic s, input logic f, input logic r,
                       input logic [15:0] rp);
    stall = s; flush = f; redirect = r; redirect_pc = rp;
    @(posedge clk);
    model_step(s, f, r, rp);
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    checks++;
    if ({imem_addr, id_valid, id_instr, id_pc_next, SEOp, halted} !==
        {16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got addr=%h v=%b instr=%h pcn=%h se=%b h=%b exp 0000 0 0000 0000 0 0",
               imem_addr, id_valid, id_instr, id_pc_next, SEOp, halted);
    end
`ifdef IF_ID_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'h0000) begin
      errors++; $display("FAIL reset_stall_cnt got %h exp 0000", stall_cnt);
    end
`endif
  endtask

  task automatic test_fetch_decode;
    mem[0] = 16'h1234; mem[1] = 16'hA3C5;
    apply_reset();
    cycle(0, 0, 0, 16'h0);
    checks++;
    if ({id_instr, id_pc_next, id_valid, SEOp} !== {16'h1234, 16'h0001, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL fetch_first got instr=%h pcn=%h v=%b se=%b exp 1234 0001 1 0",
               id_instr, id_pc_next, id_valid, SEOp);
    end
    cycle(0, 0, 0, 16'h0);
    checks++;
    if ({opcode, rd, rs, rt, const_in, SEOp} !== {4'hA, 3'd1, 3'd7, 3'd0, 6'h05, 1'b1}) begin
      errors++;
      $display("FAIL decode_shl got op=%h rd=%0d rs=%0d rt=%0d c=%h se=%b exp a 1 7 0 05 1",
               opcode, rd, rs, rt, const_in, SEOp);
    end
  endtask

  task automatic test_stall;
    logic [15:0] held;
    logic [15:0] base;
    mem[4] = 16'h2468;
    cycle(0, 0, 1, 16'h0004);
    cycle(0, 0, 0, 16'h0);
    held = 16'h2468;
    base = m_scnt;
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0, 16'h0);
      checks++;
      if (imem_addr !== 16'h0005 || id_instr !== held || id_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold cyc%0d got addr=%h instr=%h v=%b exp 0005 %h 1",
                 i, imem_addr, id_instr, id_valid, held);
      end
    end
`ifdef IF_ID_STALL_CNT_EN
    checks++;
    if (stall_cnt !== base + 16'd3) begin
      errors++; $display("FAIL stall_cnt got %h exp %h", stall_cnt, base + 16'd3);
    end
`endif
    // flush during stall: IF/ID squashed, pc still held
    cycle(1, 1, 0, 16'h0);
    checks++;
    if (imem_addr !== 16'h0005 || id_valid !== 1'b0 || id_instr !== 16'h0000) begin
      errors++;
      $display("FAIL stall_flush got addr=%h v=%b instr=%h exp 0005 0 0000",
               imem_addr, id_valid, id_instr);
    end
  endtask

  task automatic test_redirect_stall;
    mem[16'h0040] = 16'h5A5A;
    cycle(1, 0, 1, 16'h0040);
    checks++;
    if (imem_addr !== 16'h0040 || id_valid !== 1'b0 || id_instr !== 16'h0000) begin
      errors++;
      $display("FAIL redirect_stall got addr=%h v=%b instr=%h exp 0040 0 0000",
               imem_addr, id_valid, id_instr);
    end
    cycle(0, 0, 0, 16'h0);
    checks++;
    if (id_instr !== 16'h5A5A || id_pc_next !== 16'h0041 || id_valid !== 1'b1) begin
      errors++;
      $display("FAIL redirect_load got instr=%h pcn=%h v=%b exp 5a5a 0041 1",
               id_instr, id_pc_next, id_valid);
    end
  endtask

  task automatic test_wrap;
    mem[16'hFFFF] = 16'h1357;
    cycle(0, 0, 1, 16'hFFFF);
    cycle(0, 0, 0, 16'h0);
    checks++;
    if (imem_addr !== 16'h0000 || id_pc_next !== 16'h0000 || id_instr !== 16'h1357) begin
      errors++;
      $display("FAIL pc_wrap got addr=%h pcn=%h instr=%h exp 0000 0000 1357",
               imem_addr, id_pc_next, id_instr);
    end
  endtask

  task automatic test_halt;
    mem[16'h0080] = 16'hF000;
    cycle(0, 0, 1, 16'h0080);
    cycle(0, 0, 0, 16'h0);
    checks++;
    if (id_instr !== 16'hF000 || halted !== 1'b0 || imem_addr !== 16'h0081) begin
      errors++;
      $display("FAIL halt_fetch got instr=%h h=%b addr=%h exp f000 0 0081",
               id_instr, halted, imem_addr);
    end
    cycle(0, 0, 0, 16'h0);
    checks++;
    if (halted !== 1'b1 || imem_addr !== 16'h0081 || id_instr !== 16'hF000 || id_valid !== 1'b1) begin
      errors++;
      $display("FAIL halt_enter got h=%b addr=%h instr=%h v=%b exp 1 0081 f000 1",
               halted, imem_addr, id_instr, id_valid);
    end
    cycle(1, 1, 1, 16'h1234);
    cycle(0, 0, 0, 16'h0);
    checks++;
    if (halted !== 1'b1 || imem_addr !== 16'h0081 || id_instr !== 16'hF000 || id_valid !== 1'b1) begin
      errors++;
      $display("FAIL halt_ignore got h=%b addr=%h instr=%h v=%b exp 1 0081 f000 1",
               halted, imem_addr, id_instr, id_valid);
    end
    apply_reset();
    checks++;
    if (halted !== 1'b0 || imem_addr !== 16'h0000 || id_valid !== 1'b0) begin
      errors++;
      $display("FAIL halt_reset got h=%b addr=%h v=%b exp 0 0000 0",
               halted, imem_addr, id_valid);
    end
    mem[16'h0080] = 16'h0000;
  endtask

  task automatic test_random;
    logic [EW-1:0] got, exp;
    logic s, f, r;
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      s = ($urandom_range(0, 9) < 3);
      f = ($urandom_range(0, 9) < 1);
      r = ($urandom_range(0, 9) < 1);
      cycle(s, f, r, 16'($urandom));
      exp_q.push_back(model_view());
      got = {imem_addr, id_valid, id_instr, id_pc_next, opcode, rd, rs, rt,
             const_in, SEOp, halted};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random cyc%0d got %h exp %h", n, got, exp);
      end
`ifdef IF_ID_STALL_CNT_EN
      checks++;
      if (stall_cnt !== m_scnt) begin
        errors++; $display("FAIL random_stall_cnt cyc%0d got %h exp %h", n, stall_cnt, m_scnt);
      end
`endif
    end
  endtask

  task automatic test_async_reset;
    mem[0] = 16'hA000;
    apply_reset();
    cycle(0, 0, 0, 16'h0);
    checks++;
    if (id_valid !== 1'b1 || SEOp !== 1'b1) begin
      errors++; $display("FAIL async_pre got v=%b se=%b exp 1 1", id_valid, SEOp);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (id_valid !== 1'b0 || SEOp !== 1'b0 || imem_addr !== 16'h0000) begin
      errors++;
      $display("FAIL async_reset got v=%b se=%b addr=%h exp 0 0 0000",
               id_valid, SEOp, imem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int a = 0; a < 65536; a++) begin
      mem[a] = 16'($urandom);
      if (mem[a][15:12] == 4'hF) mem[a][15:12] = 4'hE;
    end
    @(negedge clk);
    test_reset();
    test_fetch_decode();
    test_stall();
    test_redirect_stall();
    test_wrap();
    test_halt();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
